regfile_burst: RTL and testbench

Parametrised register file, successor to the fixed 13 x 26-bit bank in the datapath.
- Two synchronous read ports with write-to-read bypass.
- One single-word write port.
- One handshaked burst-write port that fills consecutive registers with wrap-around, for bulk loads from the memory interface.
- Full bank exported for debug and display.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_burst_if.sv | 26 ++
 rtl/regfile_burst_ctrl.sv | 80 ++++++++
 rtl/regfile_burst.sv | 93 +++++++++
 tb/tb_regfile_burst.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the burst-loadable register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 26;
    localparam int DEFAULT_NUM_REGS = 13;

    typedef enum logic {
        IDLE,
        BURST
    } burst_state_e;

    // Next burst pointer: steps through 0..num_regs-1 and wraps back to 0.
    function automatic int wrap_inc(input int ptr, input int num_regs);
        return (ptr >= num_regs - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/regfile_burst_if.sv
// Burst-load handshake between the memory interface (master) and the register file (slave).
interface regfile_burst_if #(
    parameter  int DATA_W   = regfile_pkg::DEFAULT_DATA_W,
    parameter  int NUM_REGS = regfile_pkg::DEFAULT_NUM_REGS,
    localparam int AW       = $clog2(NUM_REGS)
);

    logic              burst_start;
    logic [AW-1:0]     burst_base;
    logic [AW:0]       burst_len;
    logic              burst_valid;
    logic [DATA_W-1:0] burst_data;
    logic              burst_ready;
    logic              burst_busy;

    modport master (
        output burst_start, burst_base, burst_len, burst_valid, burst_data,
        input  burst_ready, burst_busy
    );

    modport slave (
        input  burst_start, burst_base, burst_len, burst_valid, burst_data,
        output burst_ready, burst_busy
    );

endinterface

// File: rtl/regfile_burst_ctrl.sv
// Burst sequencer: validates a request, then steps a wrapping pointer once per accepted beat.
module regfile_burst_ctrl
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          burst_start,
    input  logic [AW-1:0] burst_base,
    input  logic [AW:0]   burst_len,
    input  logic          burst_valid,
    output logic          burst_ready,
    output logic          burst_busy,
    output logic          beat_we,
    output logic [AW-1:0] beat_addr,
    output logic          start_err
);

    burst_state_e  state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          req_ok;

    assign req_ok = (burst_len != '0)
                 && (32'(burst_len) <= NUM_REGS)
                 && (32'(burst_base) < NUM_REGS);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        beat_we   = 1'b0;
        start_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (burst_start) begin
                    if (req_ok) begin
                        ptr_d   = burst_base;
                        cnt_d   = burst_len;
                        state_d = BURST;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end
            BURST: begin
                if (burst_valid) begin
                    beat_we = 1'b1;
                    ptr_d   = AW'(wrap_inc(32'(ptr_q), NUM_REGS));
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == (AW+1)'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign burst_ready = (state_q == BURST);
    assign burst_busy  = (state_q == BURST);
    assign beat_addr   = ptr_q;

endmodule

// File: rtl/regfile_burst.sv
// Register file with two bypassed synchronous read ports, a single write port and a burst loader.
module regfile_burst
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEFAULT_DATA_W,
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd_valid,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    regfile_burst_if.slave    bus,
    output logic              err,
    output logic [DATA_W-1:0] bank [NUM_REGS]
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              beat_we, start_err;
    logic [AW-1:0]     beat_addr;
    logic              single_ok, wr_en, rd_err, wr_err;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data, rd1_d, rd2_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    regfile_burst_ctrl #(.NUM_REGS(NUM_REGS)) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .burst_start (bus.burst_start),
        .burst_base  (bus.burst_base),
        .burst_len   (bus.burst_len),
        .burst_valid (bus.burst_valid),
        .burst_ready (bus.burst_ready),
        .burst_busy  (bus.burst_busy),
        .beat_we     (beat_we),
        .beat_addr   (beat_addr),
        .start_err   (start_err)
    );

    // The burst port owns the bank while busy, so the two write sources never collide.
    assign single_ok = we && !bus.burst_busy && in_range(wa);
    assign wr_en     = beat_we || single_ok;
    assign wr_addr   = beat_we ? beat_addr : wa;
    assign wr_data   = beat_we ? bus.burst_data : wd;

    assign rd_err = rd_en && (!in_range(ra1) || !in_range(ra2));
    assign wr_err = we && (!in_range(wa) || bus.burst_busy);

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (in_range(ra1)) rd1_d = (wr_en && wr_addr == ra1) ? wr_data : regs[ra1];
        if (in_range(ra2)) rd2_d = (wr_en && wr_addr == ra2) ? wr_data : regs[ra2];
    end

    // NOTE: the whole bank must clear on reset, so it is built from resettable flops rather than a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1      <= '0;
            rd2      <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd1 <= rd1_d;
                rd2 <= rd2_d;
            end
            err <= err | rd_err | wr_err | start_err;
        end
    end

    assign bank = regs;

endmodule

// File: tb/tb_regfile_burst.sv
// Self-checking bench for regfile_burst: directed vector table, burst corner sequences, random vs. model.
module tb_regfile_burst;
    import regfile_pkg::*;

    localparam int DW = DEFAULT_DATA_W;
    localparam int NR = DEFAULT_NUM_REGS;
    localparam int AW = $clog2(NR);

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic [AW-1:0] ra1, ra2;
    logic [DW-1:0] rd1, rd2;
    logic          rd_valid;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          err;
    logic [DW-1:0] bank [NR];

    regfile_burst_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

    regfile_burst #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .rd_valid (rd_valid),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .bus      (bus),
        .err      (err),
        .bank     (bank)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain arrays and integers, updated once per clock edge.
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_rd1, m_rd2;
    bit            m_valid, m_err, m_busy;
    int            m_ptr, m_left;

    typedef struct {
        logic          rd_en;
        logic [AW-1:0] ra1, ra2;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] e_rd1, e_rd2;
        logic          e_valid, e_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_rd1 = '0; m_rd2 = '0;
        m_valid = 0; m_err = 0; m_busy = 0;
        m_ptr = 0; m_left = 0;
    endtask

    task automatic model_step();
        int            widx;
        logic [DW-1:0] wval;
        widx = -1;
        wval = '0;
        if (m_busy) begin
            if (we) m_err = 1;
            if (bus.burst_valid) begin
                widx   = m_ptr;
                wval   = bus.burst_data;
                m_ptr  = (m_ptr + 1) % NR;
                m_left = m_left - 1;
                if (m_left == 0) m_busy = 0;
            end
        end else begin
            if (we) begin
                if (int'(wa) < NR) begin
                    widx = int'(wa);
                    wval = wd;
                end else begin
                    m_err = 1;
                end
            end
            if (bus.burst_start) begin
                if (int'(bus.burst_len) >= 1 && int'(bus.burst_len) <= NR && int'(bus.burst_base) < NR) begin
                    m_busy = 1;
                    m_ptr  = int'(bus.burst_base);
                    m_left = int'(bus.burst_len);
                end else begin
                    m_err = 1;
                end
            end
        end
        if (rd_en) begin
            if (int'(ra1) >= NR || int'(ra2) >= NR) m_err = 1;
            m_rd1 = (int'(ra1) >= NR) ? '0 : (widx == int'(ra1)) ? wval : m_regs[ra1];
            m_rd2 = (int'(ra2) >= NR) ? '0 : (widx == int'(ra2)) ? wval : m_regs[ra2];
        end
        m_valid = rd_en;
        if (widx >= 0) m_regs[widx] = wval;
    endtask

    task automatic compare_all();
        check("rd1", rd1, m_rd1);
        check("rd2", rd2, m_rd2);
        check("rd_valid", DW'(rd_valid), DW'(m_valid));
        check("err", DW'(err), DW'(m_err));
        check("burst_ready", DW'(bus.burst_ready), DW'(m_busy));
        check("burst_busy", DW'(bus.burst_busy), DW'(m_busy));
        for (int i = 0; i < NR; i++) check($sformatf("bank[%0d]", i), bank[i], m_regs[i]);
    endtask

    task automatic idle_inputs();
        rd_en = 0; ra1 = '0; ra2 = '0;
        we = 0; wa = '0; wd = '0;
        bus.burst_start = 0; bus.burst_base = '0; bus.burst_len = '0;
        bus.burst_valid = 0; bus.burst_data = '0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
    endtask

    task automatic start_burst(input int base, input int len);
        bus.burst_start = 1;
        bus.burst_base  = AW'(base);
        bus.burst_len   = (AW+1)'(len);
        cycle();
        bus.burst_start = 0;
    endtask

    initial begin
        logic       vpat [5];
        logic [3:0] dpat [5];

        rst = 1'b0;
        idle_inputs();
        model_reset();

        vecs[0] = '{1'b1, 4'd3,  4'd12, 1'b0, 4'd0,  26'h0,       26'h0,       26'h0,       1'b1, 1'b0};
        vecs[1] = '{1'b1, 4'd5,  4'd0,  1'b1, 4'd5,  26'h2ABCDEF, 26'h2ABCDEF, 26'h0,       1'b1, 1'b0};
        vecs[2] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd12, 26'h3FFFFFF, 26'h2ABCDEF, 26'h0,       1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'd12, 4'd5,  1'b1, 4'd0,  26'h0000001, 26'h3FFFFFF, 26'h2ABCDEF, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 4'd0,  4'd0,  1'b0, 4'd0,  26'h0,       26'h0000001, 26'h0000001, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'd13, 4'd5,  1'b0, 4'd0,  26'h0,       26'h0,       26'h2ABCDEF, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 4'd12, 4'd15, 1'b0, 4'd0,  26'h0,       26'h3FFFFFF, 26'h0,       1'b1, 1'b1};

        // Directed read/write table from reset.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            rd_en = vecs[i].rd_en; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            cycle();
            check($sformatf("vec%0d rd1", i), rd1, vecs[i].e_rd1);
            check($sformatf("vec%0d rd2", i), rd2, vecs[i].e_rd2);
            check($sformatf("vec%0d rd_valid", i), DW'(rd_valid), DW'(vecs[i].e_valid));
            check($sformatf("vec%0d err", i), DW'(err), DW'(vecs[i].e_err));
        end
        check("vec bank5", bank[5], 26'h2ABCDEF);
        idle_inputs();

        // Wrapping burst with one stall cycle.
        do_reset();
        start_burst(11, 4);
        check("wrap busy after start", DW'(bus.burst_busy), DW'(1));
        vpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        dpat = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 5; i++) begin
            bus.burst_valid = vpat[i];
            bus.burst_data  = DW'(dpat[i]);
            cycle();
            check($sformatf("wrap ready beat%0d", i), DW'(bus.burst_ready), (i < 4) ? DW'(1) : DW'(0));
        end
        idle_inputs();
        check("wrap reg11", bank[11], DW'(1));
        check("wrap reg12", bank[12], DW'(2));
        check("wrap reg0", bank[0], DW'(3));
        check("wrap reg1", bank[1], DW'(4));
        check("wrap err", DW'(err), DW'(0));

        // Single write blocked during a burst.
        start_burst(5, 2);
        bus.burst_valid = 1; bus.burst_data = 26'h00000AA;
        we = 1; wa = 4'd2; wd = 26'h0000055;
        cycle();
        check("blocked err", DW'(err), DW'(1));
        check("blocked reg2", bank[2], DW'(0));
        we = 0; bus.burst_data = 26'h00000BB;
        cycle();
        idle_inputs();
        check("blocked busy done", DW'(bus.burst_busy), DW'(0));
        check("blocked reg5", bank[5], 26'h00000AA);
        check("blocked reg6", bank[6], 26'h00000BB);

        // Out-of-range single write.
        do_reset();
        we = 1; wa = 4'd14; wd = 26'h1234567;
        cycle();
        idle_inputs();
        check("oor write err", DW'(err), DW'(1));

        // Illegal burst requests.
        do_reset();
        start_burst(0, 0);
        check("len0 busy", DW'(bus.burst_busy), DW'(0));
        check("len0 err", DW'(err), DW'(1));
        start_burst(0, 14);
        check("len14 busy", DW'(bus.burst_busy), DW'(0));
        start_burst(13, 1);
        check("base13 busy", DW'(bus.burst_busy), DW'(0));

        // Asynchronous reset mid-burst.
        do_reset();
        start_burst(0, 6);
        bus.burst_valid = 1; bus.burst_data = 26'h0000011;
        cycle();
        bus.burst_data = 26'h0000022;
        cycle();
        check("pre-abort reg1", bank[1], 26'h0000022);
        #2;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check("abort busy", DW'(bus.burst_busy), DW'(0));
        check("abort ready", DW'(bus.burst_ready), DW'(0));
        check("abort reg0", bank[0], DW'(0));
        check("abort reg1", bank[1], DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
        check("post-abort idle", DW'(bus.burst_busy), DW'(0));
        start_burst(3, 1);
        check("new burst busy", DW'(bus.burst_busy), DW'(1));
        bus.burst_valid = 1; bus.burst_data = 26'h0000007;
        cycle();
        idle_inputs();
        check("new burst reg3", bank[3], DW'(7));
        check("new burst done", DW'(bus.burst_busy), DW'(0));

        // Randomized traffic against the model.
        for (int n = 0; n < 480; n++) begin
            if (n % 40 == 0) do_reset();
            rd_en = 1'($urandom_range(0, 1));
            ra1   = AW'($urandom_range(0, 15));
            ra2   = AW'($urandom_range(0, 15));
            we    = ($urandom_range(0, 3) == 0);
            wa    = AW'($urandom_range(0, 15));
            wd    = DW'($urandom);
            bus.burst_start = ($urandom_range(0, 5) == 0);
            bus.burst_base  = AW'($urandom_range(0, 14));
            bus.burst_len   = (AW+1)'($urandom_range(0, 14));
            bus.burst_valid = ($urandom_range(0, 2) != 0);
            bus.burst_data  = DW'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
